// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB slave: FSM state encoding,
// default device address and byte/register-address widths.
package sccb_pkg;

    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 16;
    localparam int DEV_ADDR_W = 7;

    localparam logic [DEV_ADDR_W-1:0] DEV_ADDR_DEFAULT = 7'h3C;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        REG_HI,
        ACK_HI,
        REG_LO,
        ACK_LO,
        WDATA,
        ACK_W,
        RDATA,
        RACK
    } sccb_state_e;

endpackage

// File: rtl/sccb_slave_filter.sv
// SCL/SDA conditioning: 2-FF synchronizer, FILTER_LEN-sample stability filter,
// and single-cycle SCL rise/fall and START/STOP pulses.
module sccb_slave_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0]            scl_sync_q, sda_sync_q;
    logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
    logic                  scl_q, sda_q;
    logic                  scl_d, sda_d;
    logic                  scl_rise_q, scl_fall_q, start_q, stop_q;

    // A level is accepted only once the whole history window agrees.
    always_comb begin
        scl_d = scl_q;
        sda_d = sda_q;
        if (&scl_hist_q)
            scl_d = 1'b1;
        else if (~|scl_hist_q)
            scl_d = 1'b0;
        if (&sda_hist_q)
            sda_d = 1'b1;
        else if (~|sda_hist_q)
            sda_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= (scl_hist_q << 1) | FILTER_LEN'(scl_sync_q[1]);
            sda_hist_q <= (sda_hist_q << 1) | FILTER_LEN'(sda_sync_q[1]);
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            scl_rise_q <= ~scl_q & scl_d;
            scl_fall_q <= scl_q & ~scl_d;
            // SCL must be high both before and after the SDA change.
            start_q    <= scl_q & scl_d & sda_q & ~sda_d;
            stop_q     <= scl_q & scl_d & ~sda_q & sda_d;
        end
    end

    assign sda_o      = sda_q;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB (I2C-style) register-access slave with 16-bit register addressing.
// Read transfers are built only when SCCB_SLAVE_READ_EN is defined.
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [DEV_ADDR_W-1:0] DEV_ADDR   = DEV_ADDR_DEFAULT,
    parameter int                    FILTER_LEN = 3
) (
    input  logic              clk_25M,
    input  logic              camera_rst,
    input  logic              i2c_sclk,
    input  logic              i2c_sdat_in,
    output logic              i2c_sdat_oe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              rd_req,
    input  logic [BYTE_W-1:0] rd_data,
    output logic              busy
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;

    sccb_slave_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk_i      (clk_25M),
        .rst_i      (camera_rst),
        .scl_i      (i2c_sclk),
        .sda_i      (i2c_sdat_in),
        .sda_o      (sda_f),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    sccb_state_e       state_q;
    logic [3:0]        bit_cnt_q;
    logic [BYTE_W-1:0] shift_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [BYTE_W-1:0] wr_data_q;
    logic              oe_q, wr_en_q, rd_req_q, busy_q;
    logic              rx_state, byte_done, dev_match;

    assign rx_state  = state_q inside {DEVADDR, REG_HI, REG_LO, WDATA};
    assign byte_done = scl_fall && (bit_cnt_q == 4'd8);
    assign dev_match = (shift_q[7:1] == DEV_ADDR);

`ifdef SCCB_SLAVE_READ_EN
    logic [BYTE_W-1:0] tx_q;
    logic              rd_pend_q, rw_q, mack_q;
`else
    logic unused_rd;
    assign unused_rd = ^rd_data;
`endif

    always_ff @(posedge clk_25M) begin
        if (camera_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            oe_q       <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
            tx_q       <= '0;
            rd_pend_q  <= 1'b0;
            rw_q       <= 1'b0;
            mack_q     <= 1'b0;
`endif
        end else begin
            wr_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
            // Read data arrives one cycle after the request strobe.
            rd_pend_q <= rd_req_q;
            if (rd_pend_q)
                tx_q <= rd_data;
`endif
            if (stop_det) begin
                state_q <= IDLE;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (start_det) begin
                state_q   <= DEVADDR;
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
            end else begin
                if (rx_state && scl_rise && bit_cnt_q != 4'd8) begin
                    shift_q   <= {shift_q[BYTE_W-2:0], sda_f};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                case (state_q)
                    DEVADDR: if (byte_done) begin
                        bit_cnt_q <= '0;
                        if (dev_match && !shift_q[0]) begin
                            state_q <= ACK_DEV;
                            oe_q    <= 1'b1;
                            busy_q  <= 1'b1;
`ifdef SCCB_SLAVE_READ_EN
                            rw_q    <= 1'b0;
                        end else if (dev_match && shift_q[0]) begin
                            // Fetch early so the MSB is ready at the ACK's closing fall.
                            state_q  <= ACK_DEV;
                            oe_q     <= 1'b1;
                            busy_q   <= 1'b1;
                            rw_q     <= 1'b1;
                            rd_req_q <= 1'b1;
`endif
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ACK_DEV: if (scl_fall) begin
`ifdef SCCB_SLAVE_READ_EN
                        if (rw_q) begin
                            state_q   <= RDATA;
                            bit_cnt_q <= '0;
                            oe_q      <= ~tx_q[7];
                        end else begin
                            state_q <= REG_HI;
                            oe_q    <= 1'b0;
                        end
`else
                        state_q <= REG_HI;
                        oe_q    <= 1'b0;
`endif
                    end
                    REG_HI: if (byte_done) begin
                        reg_addr_q[15:8] <= shift_q;
                        bit_cnt_q        <= '0;
                        state_q          <= ACK_HI;
                        oe_q             <= 1'b1;
                    end
                    ACK_HI: if (scl_fall) begin
                        state_q <= REG_LO;
                        oe_q    <= 1'b0;
                    end
                    REG_LO: if (byte_done) begin
                        reg_addr_q[7:0] <= shift_q;
                        bit_cnt_q       <= '0;
                        state_q         <= ACK_LO;
                        oe_q            <= 1'b1;
                    end
                    ACK_LO: if (scl_fall) begin
                        state_q <= WDATA;
                        oe_q    <= 1'b0;
                    end
                    WDATA: if (byte_done) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= shift_q;
                        bit_cnt_q <= '0;
                        state_q   <= ACK_W;
                        oe_q      <= 1'b1;
                    end
                    ACK_W: if (scl_fall) begin
                        reg_addr_q <= reg_addr_q + 16'd1;
                        state_q    <= WDATA;
                        oe_q       <= 1'b0;
                    end
`ifdef SCCB_SLAVE_READ_EN
                    RDATA: begin
                        if (scl_rise)
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q    <= RACK;
                                oe_q       <= 1'b0;
                                reg_addr_q <= reg_addr_q + 16'd1;
                            end else begin
                                oe_q <= ~tx_q[6];
                                tx_q <= tx_q << 1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            mack_q   <= ~sda_f;
                            rd_req_q <= ~sda_f;
                        end
                        if (scl_fall) begin
                            if (mack_q) begin
                                state_q   <= RDATA;
                                bit_cnt_q <= '0;
                                oe_q      <= ~tx_q[7];
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sdat_oe = oe_q;
    assign wr_en       = wr_en_q;
    assign reg_addr    = reg_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
`ifdef SCCB_SLAVE_READ_EN
    assign rd_req      = rd_req_q;
`else
    assign rd_req      = 1'b0;
`endif

endmodule
